// File: rtl/pkt_gen_pkg.sv
// Shared constants, enums and the per-sample pattern function for pkt_gen.
package pkt_gen_pkg;

    localparam int LANES          = 24;
    localparam int LANE_W         = 36;
    localparam int SMP_W          = 12;
    localparam int RAMP_STRIDE_96 = 72;
    localparam int RAMP_STRIDE_48 = 36;

    localparam logic [14:0] LFSR_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        RAMP  = 2'd0,
        FIXED = 2'd1,
        ALT   = 2'd2,
        PRBS  = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Value of one sample slot; idx is the slot's sample index s = 3*lane + k.
    function automatic logic [SMP_W-1:0] sample_value(
        input pattern_e         pat,
        input logic [SMP_W-1:0] base,
        input logic [SMP_W-1:0] fixed,
        input logic [SMP_W-1:0] prbs,
        input logic             odd_word,
        input logic [SMP_W-1:0] idx
    );
        logic [SMP_W-1:0] v;
        case (pat)
            RAMP:    v = base + idx;
            FIXED:   v = fixed;
            ALT:     v = odd_word ? ~fixed : fixed;
            default: v = prbs ^ idx;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pkt_gen_if.sv
// Register-file controls in, self-test lane buses and status out.
interface pkt_gen_if #(
    parameter int LANES  = pkt_gen_pkg::LANES,
    parameter int LANE_W = pkt_gen_pkg::LANE_W
);
    logic                              rf_self_test_mode;
    logic                              rf_96path_en;
    logic                              rf_pkt_gen_start;
    logic [1:0]                        rf_pkt_gen_pattern;
    logic [pkt_gen_pkg::SMP_W-1:0]     rf_pkt_gen_fixed;
    logic [15:0]                       rf_pkt_gen_len;
    logic [15:0]                       rf_pkt_gen_gap;
    logic [15:0]                       rf_pkt_gen_num;

    logic [LANES*LANE_W-1:0]           pkt_gen_data;
    logic [(LANES/2)*LANE_W-1:0]       pkt_gen_48data;
    logic                              pkt_gen_vld;
    logic                              pkt_gen_busy;
    logic                              pkt_gen_done;

    // Generator side.
    modport master (
        input  rf_self_test_mode, rf_96path_en, rf_pkt_gen_start, rf_pkt_gen_pattern,
               rf_pkt_gen_fixed, rf_pkt_gen_len, rf_pkt_gen_gap, rf_pkt_gen_num,
        output pkt_gen_data, pkt_gen_48data, pkt_gen_vld, pkt_gen_busy, pkt_gen_done
    );

    // Register file / capture side.
    modport slave (
        output rf_self_test_mode, rf_96path_en, rf_pkt_gen_start, rf_pkt_gen_pattern,
               rf_pkt_gen_fixed, rf_pkt_gen_len, rf_pkt_gen_gap, rf_pkt_gen_num,
        input  pkt_gen_data, pkt_gen_48data, pkt_gen_vld, pkt_gen_busy, pkt_gen_done
    );
endinterface

// File: rtl/pkt_gen_lfsr15.sv
// 15-bit Fibonacci LFSR, x^15+x^14+1, with seed load and advance enable.
module pkt_gen_lfsr15 import pkt_gen_pkg::*; #(
    parameter int OUT_W = SMP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [OUT_W-1:0] prbs_o
);
    logic [14:0] lfsr_q, lfsr_d;

    // Seed load wins over advance.
    // NOTE: combinational blocks assign a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (adv_i) begin
            lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign prbs_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/pkt_gen.sv
// Self-test burst generator: FSM, burst/gap counters, ramp base and lane fill.
module pkt_gen #(
    parameter int LANES  = pkt_gen_pkg::LANES,
    parameter int LANE_W = pkt_gen_pkg::LANE_W,
    parameter int SMP_W  = pkt_gen_pkg::SMP_W
) (
    input  logic      clk,
    input  logic      rst_n,
    pkt_gen_if.master bus
);
    import pkt_gen_pkg::*;

    localparam int DATA_W = LANES * LANE_W;

    state_e            state_q, state_d;
    logic              c96_q, c96_d;
    pattern_e          pat_q, pat_d;
    logic [SMP_W-1:0]  fixed_q, fixed_d;
    logic [15:0]       len_m1_q, len_m1_d;
    logic [15:0]       gap_q, gap_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [15:0]       burst_cnt_q, burst_cnt_d;
    logic [SMP_W-1:0]  base_q, base_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              lfsr_load, lfsr_adv;
    logic [SMP_W-1:0]  prbs;
    logic [SMP_W-1:0]  stride;
    logic              start_ok;
    logic [DATA_W-1:0] word_w;

    pkt_gen_lfsr15 #(.OUT_W(SMP_W)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .adv_i  (lfsr_adv),
        .prbs_o (prbs)
    );

    assign stride   = c96_q ? SMP_W'(RAMP_STRIDE_96) : SMP_W'(RAMP_STRIDE_48);
    // busy_q also blocks a start in the single IDLE cycle before busy falls.
    assign start_ok = bus.rf_self_test_mode && bus.rf_pkt_gen_start &&
                      (state_q == IDLE) && !busy_q;

    // Candidate word for this cycle; upper lanes are blanked on the 48-path bus.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar k = 0; k < 3; k++) begin : g_smp
            assign word_w[l*LANE_W + k*SMP_W +: SMP_W] =
                (!c96_q && (l >= LANES/2)) ? '0 :
                sample_value(pat_q, base_q, fixed_q, prbs, word_cnt_q[0], SMP_W'(3*l + k));
        end
    end

    // Next-state, counters and registered outputs. Outputs lag the FSM by one
    // edge, so done is raised in IDLE while busy_q still reflects the burst.
    always_comb begin
        state_d     = state_q;
        c96_d       = c96_q;
        pat_d       = pat_q;
        fixed_d     = fixed_q;
        len_m1_d    = len_m1_q;
        gap_d       = gap_q;
        num_d       = num_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        burst_cnt_d = burst_cnt_q;
        base_d      = base_q;
        data_d      = '0;
        vld_d       = 1'b0;
        busy_d      = bus.rf_self_test_mode && (state_q != IDLE);
        done_d      = done_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        if (!bus.rf_self_test_mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        done_d = 1'b1;
                    end
                    if (start_ok) begin
                        state_d     = BURST;
                        c96_d       = bus.rf_96path_en;
                        pat_d       = pattern_e'(bus.rf_pkt_gen_pattern);
                        fixed_d     = bus.rf_pkt_gen_fixed;
                        len_m1_d    = (bus.rf_pkt_gen_len == 16'd0) ? 16'd0 : bus.rf_pkt_gen_len - 16'd1;
                        gap_d       = bus.rf_pkt_gen_gap;
                        num_d       = bus.rf_pkt_gen_num;
                        word_cnt_d  = '0;
                        gap_cnt_d   = '0;
                        burst_cnt_d = '0;
                        base_d      = '0;
                        done_d      = 1'b0;
                        lfsr_load   = 1'b1;
                    end
                end
                BURST: begin
                    vld_d    = 1'b1;
                    data_d   = word_w;
                    base_d   = base_q + stride;
                    lfsr_adv = 1'b1;
                    if (word_cnt_q == len_m1_q) begin
                        word_cnt_d  = '0;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        if ((num_q != 16'd0) && (burst_cnt_q == num_q - 16'd1)) begin
                            state_d = IDLE;
                        end else if (gap_q != 16'd0) begin
                            state_d   = GAP;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == gap_q - 16'd1) begin
                        state_d   = BURST;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, latched configuration, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c96_q       <= 1'b0;
            pat_q       <= RAMP;
            fixed_q     <= '0;
            len_m1_q    <= '0;
            gap_q       <= '0;
            num_q       <= '0;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            burst_cnt_q <= '0;
            base_q      <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            c96_q       <= c96_d;
            pat_q       <= pat_d;
            fixed_q     <= fixed_d;
            len_m1_q    <= len_m1_d;
            gap_q       <= gap_d;
            num_q       <= num_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            base_q      <= base_d;
            data_q      <= data_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.pkt_gen_data   = data_q;
    assign bus.pkt_gen_48data = data_q[(LANES/2)*LANE_W-1:0];
    assign bus.pkt_gen_vld    = vld_q;
    assign bus.pkt_gen_busy   = busy_q;
    assign bus.pkt_gen_done   = done_q;

endmodule

// File: tb/tb_pkt_gen.sv
// Self-checking bench for pkt_gen: table of burst configurations checked cycle
// by cycle against a timeline model, plus abort, ignored-start and reset cases.
module tb_pkt_gen;
    import pkt_gen_pkg::*;

    localparam int DW = LANES * LANE_W;
    localparam int HW = (LANES / 2) * LANE_W;

    logic clk = 1'b0;
    logic rst_n;

    pkt_gen_if bus ();

    pkt_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] pat;
        logic [11:0] fixed;
        bit         c96;
        int         len;
        int         gap;
        int         num;
        int         exp_words;  // total valid words, -1 when continuous
        int         first_smp;  // lane0 sample0 of word 0, -1 when not tabulated
    } test_t;

    typedef struct {
        bit vld;
        bit busy;
        bit done;
        int widx;   // valid-word index since start
        int n;      // word index within its burst
    } exp_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  exp_q[$];
    test_t tests[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic test_t mk(input string name, input int pat, input int fixed, input bit c96,
                                 input int len, input int gap, input int num,
                                 input int exp_words, input int first_smp);
        test_t t;
        t.name = name; t.pat = 2'(pat); t.fixed = 12'(fixed); t.c96 = c96;
        t.len = len; t.gap = gap; t.num = num;
        t.exp_words = exp_words; t.first_smp = first_smp;
        return t;
    endfunction

    // LFSR state after a number of valid words from the seed.
    function automatic logic [14:0] lfsr_at(input int steps);
        logic [14:0] x;
        x = 15'h7FFF;
        for (int i = 0; i < steps; i++) x = {x[13:0], x[14] ^ x[13]};
        return x;
    endfunction

    // Expected 96-path bus for valid word widx (n-th in its burst).
    function automatic logic [DW-1:0] exp_word(input test_t t, input int widx, input int n);
        logic [DW-1:0] w;
        logic [14:0]   lv;
        logic [11:0]   v;
        int            stride, lanes_on, s;
        w        = '0;
        lv       = lfsr_at(widx);
        stride   = t.c96 ? 72 : 36;
        lanes_on = t.c96 ? 24 : 12;
        for (int l = 0; l < lanes_on; l++) begin
            for (int k = 0; k < 3; k++) begin
                s = 3 * l + k;
                case (t.pat)
                    2'd0:    v = 12'((widx * stride + s) % 4096);
                    2'd1:    v = t.fixed;
                    2'd2:    v = (n % 2 == 1) ? ~t.fixed : t.fixed;
                    default: v = lv[11:0] ^ 12'(s);
                endcase
                w[l*36 + k*12 +: 12] = v;
            end
        end
        return w;
    endfunction

    function automatic void push_exp(input bit vld, input bit busy, input bit done, input int widx, input int n);
        exp_t e;
        e.vld = vld; e.busy = busy; e.done = done; e.widx = widx; e.n = n;
        exp_q.push_back(e);
    endfunction

    // Per-cycle timeline after the start edge: entry 0 is the cycle right
    // after the edge that samples start.
    function automatic void build_exp(input test_t t, input int cap);
        int len_e, widx;
        len_e = (t.len == 0) ? 1 : t.len;
        widx  = 0;
        exp_q.delete();
        push_exp(0, 0, 0, 0, 0);
        for (int b = 0; (t.num != 0 && b < t.num) || (t.num == 0 && exp_q.size() < cap); b++) begin
            for (int w = 0; w < len_e; w++) begin
                push_exp(1, 1, 0, widx, w);
                widx++;
            end
            if (t.num != 0 && b == t.num - 1) break;
            for (int g = 0; g < t.gap; g++) push_exp(0, 1, 0, 0, 0);
        end
        if (t.num != 0) begin
            for (int i = 0; i < 3; i++) push_exp(0, 0, 1, 0, 0);
        end else begin
            while (exp_q.size() > cap) void'(exp_q.pop_back());
        end
    endfunction

    task automatic check_cycle(input string tag, input int c, input test_t t, input exp_t e);
        logic [DW-1:0] ew;
        ew = e.vld ? exp_word(t, e.widx, e.n) : '0;
        check($sformatf("%s c%0d vld", tag, c), DW'(bus.pkt_gen_vld), DW'(e.vld));
        check($sformatf("%s c%0d busy", tag, c), DW'(bus.pkt_gen_busy), DW'(e.busy));
        check($sformatf("%s c%0d done", tag, c), DW'(bus.pkt_gen_done), DW'(e.done));
        check($sformatf("%s c%0d data", tag, c), bus.pkt_gen_data, ew);
        check($sformatf("%s c%0d data48", tag, c), DW'(bus.pkt_gen_48data), DW'(ew[HW-1:0]));
    endtask

    task automatic drive_cfg(input test_t t);
        bus.rf_self_test_mode  = 1'b1;
        bus.rf_96path_en       = t.c96;
        bus.rf_pkt_gen_pattern = t.pat;
        bus.rf_pkt_gen_fixed   = t.fixed;
        bus.rf_pkt_gen_len     = 16'(t.len);
        bus.rf_pkt_gen_gap     = 16'(t.gap);
        bus.rf_pkt_gen_num     = 16'(t.num);
    endtask

    // Config inputs are changed after start to show they were latched.
    task automatic scramble_cfg();
        bus.rf_pkt_gen_start   = 1'b0;
        bus.rf_96path_en       = 1'($urandom);
        bus.rf_pkt_gen_pattern = 2'($urandom);
        bus.rf_pkt_gen_fixed   = 12'($urandom);
        bus.rf_pkt_gen_len     = 16'($urandom);
        bus.rf_pkt_gen_gap     = 16'($urandom);
        bus.rf_pkt_gen_num     = 16'($urandom);
    endtask

    task automatic run_test(input test_t t);
        int words;
        words = 0;
        build_exp(t, 30);
        drive_cfg(t);
        bus.rf_pkt_gen_start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) scramble_cfg();
            check_cycle(t.name, i, t, exp_q[i]);
            if (i == 1 && t.first_smp >= 0)
                check({t.name, " first sample"}, DW'(bus.pkt_gen_data[11:0]), DW'(t.first_smp));
            if (bus.pkt_gen_vld) words++;
        end
        if (t.exp_words >= 0) check({t.name, " word count"}, DW'(words), DW'(t.exp_words));
        // Drop the enable for one edge so the next run starts from IDLE.
        bus.rf_self_test_mode = 1'b0;
        @(posedge clk); #1;
        check({t.name, " idle vld"}, DW'(bus.pkt_gen_vld), '0);
        check({t.name, " idle busy"}, DW'(bus.pkt_gen_busy), '0);
        bus.rf_self_test_mode = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vld"}, DW'(bus.pkt_gen_vld), '0);
        check({tag, " busy"}, DW'(bus.pkt_gen_busy), '0);
        check({tag, " done"}, DW'(bus.pkt_gen_done), '0);
        check({tag, " data"}, bus.pkt_gen_data, '0);
        check({tag, " data48"}, DW'(bus.pkt_gen_48data), '0);
    endtask

    initial begin
        test_t t;
        int    len_r, num_r;

        rst_n                  = 1'b0;
        bus.rf_self_test_mode  = 1'b0;
        bus.rf_96path_en       = 1'b0;
        bus.rf_pkt_gen_start   = 1'b0;
        bus.rf_pkt_gen_pattern = 2'd0;
        bus.rf_pkt_gen_fixed   = '0;
        bus.rf_pkt_gen_len     = '0;
        bus.rf_pkt_gen_gap     = '0;
        bus.rf_pkt_gen_num     = '0;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.rf_self_test_mode = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post-reset idle");

        // name, pattern, fixed, 96path, len, gap, num, words, lane0 sample0 of word 0
        tests.push_back(mk("ramp96", 0, 12'h000, 1, 4,  0, 1, 4,  0));
        tests.push_back(mk("ramp48", 0, 12'h000, 0, 2,  3, 2, 4,  0));
        tests.push_back(mk("alt",    2, 12'hA5A, 1, 3,  2, 0, -1, 12'hA5A));
        tests.push_back(mk("prbs",   3, 12'h000, 1, 1,  1, 3, 3,  12'hFFF));
        tests.push_back(mk("fixed",  1, 12'h3C7, 0, 5,  0, 2, 10, 12'h3C7));
        tests.push_back(mk("len0",   0, 12'h000, 1, 0,  2, 2, 2,  0));
        tests.push_back(mk("wrap",   0, 12'h000, 1, 60, 0, 1, 60, 0));
        for (int i = 0; i < 6; i++) begin
            len_r = int'($urandom_range(0, 6));
            num_r = int'($urandom_range(0, 3));
            tests.push_back(mk($sformatf("rand%0d", i), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 4095)), 1'($urandom), len_r,
                               int'($urandom_range(0, 4)), num_r,
                               (num_r == 0) ? -1 : ((len_r == 0) ? 1 : len_r) * num_r, -1));
        end

        foreach (tests[i]) run_test(tests[i]);

        // Abort mid-burst; a start while busy is ignored; restart begins at base 0.
        t = mk("abort", 0, 12'h000, 1, 8, 0, 1, 8, 0);
        build_exp(t, 30);
        drive_cfg(t);
        bus.rf_pkt_gen_start = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            bus.rf_pkt_gen_start = 1'b0;
            check_cycle("abort", i, t, exp_q[i]);
            if (i == 2) begin
                bus.rf_pkt_gen_pattern = 2'd1;
                bus.rf_pkt_gen_start   = 1'b1;
            end
        end
        bus.rf_pkt_gen_pattern = 2'd0;
        bus.rf_self_test_mode  = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort next cycle");
        @(posedge clk); #1;
        check_all_zero("abort stays idle");
        bus.rf_self_test_mode = 1'b1;
        run_test(mk("restart", 0, 12'h000, 1, 8, 0, 1, 8, 0));

        // Asynchronous reset in the middle of a gap, then in the middle of a burst.
        for (int pass = 0; pass < 2; pass++) begin
            t = mk("rst", 0, 12'h000, 1, 2, 5, 0, -1, 0);
            build_exp(t, 30);
            drive_cfg(t);
            bus.rf_pkt_gen_start = 1'b1;
            for (int i = 0; i < ((pass == 0) ? 5 : 2); i++) begin
                @(posedge clk); #1;
                bus.rf_pkt_gen_start = 1'b0;
                check_cycle($sformatf("rst%0d", pass), i, t, exp_q[i]);
            end
            #2 rst_n = 1'b0;
            #1;
            check_all_zero($sformatf("async reset %0d", pass));
            @(posedge clk); #1;
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_all_zero($sformatf("after reset %0d c%0d", pass, i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
